// File: rtl/sn74169_timer_ctrl.sv
// rtl/sn74169_timer_ctrl.sv - interval timer sequencer driving an external sn74169 up/down counter
module sn74169_timer_ctrl #(
   parameter int W  = 4,
   parameter int EW = 8
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          START,
   input  logic          STOP,
   input  logic          DIR_UP,
   input  logic [W-1:0]  PRESET,
   input  logic [EW-1:0] PERIODS,
   output logic [W-1:0]  CNT_A,
   output logic          CNT_LOADB,
   output logic          CNT_ENPB,
   output logic          CNT_ENTB,
   output logic          CNT_U_DB,
   input  logic          CNT_RCOB,
   output logic          BUSY,
   output logic          TICK,
   output logic          DONE,
   output logic [EW-1:0] EVT_COUNT
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2
   } state_t;

   state_t        state, state_d;
   logic          blank, blank_d;
   logic [EW-1:0] periods_q, periods_d;
   logic [W-1:0]  preset_d;
   logic          dir_d;
   logic [EW-1:0] evt_d, evt_inc;
   logic          tick_d, done_d;
   logic          term_event;

   always_comb begin
      state_d    = state;
      blank_d    = 1'b0;
      periods_d  = periods_q;
      preset_d   = CNT_A;
      dir_d      = CNT_U_DB;
      evt_d      = EVT_COUNT;
      tick_d     = 1'b0;
      done_d     = 1'b0;
      evt_inc    = EVT_COUNT + EW'(1);
      // RCOB in the first RUN cycle reflects the counter's pre-load value
      term_event = (state == RUN) && !blank && !CNT_RCOB;

      if (STOP) begin
         state_d = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (START) begin
                  preset_d  = PRESET;
                  dir_d     = DIR_UP;
                  periods_d = PERIODS;
                  evt_d     = '0;
                  state_d   = LOAD;
               end
            end
            LOAD: begin
               state_d = RUN;
               blank_d = 1'b1;
            end
            RUN: begin
               if (term_event) begin
                  tick_d = 1'b1;
                  evt_d  = evt_inc;
                  if ((periods_q != '0) && (evt_inc == periods_q)) begin
                     done_d  = 1'b1;
                     state_d = IDLE;
                  end else begin
                     state_d = LOAD;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Counter pins are registered from the next state so they line up with it
   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= IDLE;
         blank     <= 1'b0;
         periods_q <= '0;
         CNT_A     <= '0;
         CNT_U_DB  <= 1'b1;
         CNT_LOADB <= 1'b1;
         CNT_ENPB  <= 1'b1;
         CNT_ENTB  <= 1'b1;
         BUSY      <= 1'b0;
         TICK      <= 1'b0;
         DONE      <= 1'b0;
         EVT_COUNT <= '0;
      end else begin
         state     <= state_d;
         blank     <= blank_d;
         periods_q <= periods_d;
         CNT_A     <= preset_d;
         CNT_U_DB  <= dir_d;
         CNT_LOADB <= (state_d != LOAD);
         CNT_ENPB  <= (state_d != RUN);
         CNT_ENTB  <= (state_d != RUN);
         BUSY      <= (state_d != IDLE);
         TICK      <= tick_d;
         DONE      <= done_d;
         EVT_COUNT <= evt_d;
      end
   end

endmodule

// File: tb/tb_sn74169_timer_ctrl.sv
// tb/tb_sn74169_timer_ctrl.sv - self-checking bench for sn74169_timer_ctrl with a behavioural counter
module tb_sn74169_timer_ctrl;

   logic       CLK = 1'b0;
   logic       RST, START, STOP, DIR_UP, CNT_RCOB;
   logic [3:0] PRESET, CNT_A;
   logic [7:0] PERIODS, EVT_COUNT;
   logic       CNT_LOADB, CNT_ENPB, CNT_ENTB, CNT_U_DB, BUSY, TICK, DONE;
   int         passed = 0;
   int         total  = 0;

   always #5 CLK = ~CLK;

   sn74169_timer_ctrl #(.W(4), .EW(8)) dut (
      .CLK(CLK), .RST(RST), .START(START), .STOP(STOP), .DIR_UP(DIR_UP),
      .PRESET(PRESET), .PERIODS(PERIODS), .CNT_A(CNT_A), .CNT_LOADB(CNT_LOADB),
      .CNT_ENPB(CNT_ENPB), .CNT_ENTB(CNT_ENTB), .CNT_U_DB(CNT_U_DB),
      .CNT_RCOB(CNT_RCOB), .BUSY(BUSY), .TICK(TICK), .DONE(DONE),
      .EVT_COUNT(EVT_COUNT)
   );

   // sn74169 model: registered RCOB taken from the value before each edge
   logic [3:0] cq = 4'd15;
   logic       crcob = 1'b1;
   always @(posedge CLK) begin
      if (!CNT_LOADB) cq <= CNT_A;
      else if (!CNT_ENPB && !CNT_ENTB) cq <= CNT_U_DB ? cq + 4'd1 : cq - 4'd1;
      crcob <= ~(CNT_U_DB ? (cq == 4'd15) : (cq == 4'd0));
   end
   assign CNT_RCOB = crcob;

   function automatic logic [18:0] obs();
      return {CNT_A, CNT_LOADB, CNT_ENPB, CNT_ENTB, CNT_U_DB, BUSY, TICK, DONE, EVT_COUNT};
   endfunction

   task automatic check(input string name, input longint act, input longint exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic start_run(input logic dir, input logic [3:0] pre, input logic [7:0] per);
      @(negedge CLK);
      DIR_UP = dir; PRESET = pre; PERIODS = per; START = 1'b1; STOP = 1'b0;
   endtask

   typedef struct {
      logic       dir;
      logic [3:0] preset;
      logic [7:0] periods;
      int         first;
      int         spacing;
      int         done_c;
      logic [3:0] left;
   } vec_t;

   localparam logic [18:0] RESET_OBS = {4'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};

   initial begin
      vec_t        tbl [6];
      int          first, second, donec, nt, evt255, evt256, saw_done;
      int          n, dd, s, end_c, lim, lc, stopping;
      logic        rdir, busy_e, tick_e, done_e, onb, loadb_e, enpb_e;
      logic [3:0]  rpre;
      logic [7:0]  rper, evt_e;

      tbl[0] = '{1'b1, 4'd15, 8'd2,  4, 3,  7, 4'd1};
      tbl[1] = '{1'b1, 4'd10, 8'd3,  9, 8, 25, 4'd1};
      tbl[2] = '{1'b0, 4'd3,  8'd1,  7, 0,  7, 4'd14};
      tbl[3] = '{1'b0, 4'd0,  8'd2,  4, 3,  7, 4'd14};
      tbl[4] = '{1'b1, 4'd0,  8'd1, 19, 0, 19, 4'd1};
      tbl[5] = '{1'b0, 4'd15, 8'd1, 19, 0, 19, 4'd14};

      RST = 1'b1; START = 1'b0; STOP = 1'b0; DIR_UP = 1'b0; PRESET = 4'd0; PERIODS = 8'd0;
      repeat (2) @(negedge CLK);
      check("reset_values", obs(), RESET_OBS);
      RST = 1'b0;
      @(negedge CLK);
      check("idle_after_reset", obs(), RESET_OBS);

      // Table rows; row 0 starts with the counter parked at 15 so the blanking cycle sees stale RCOB
      for (int r = 0; r < 6; r++) begin
         start_run(tbl[r].dir, tbl[r].preset, tbl[r].periods);
         first = -1; second = -1; donec = -1; nt = 0;
         for (int c = 1; c <= 60 && donec < 0; c++) begin
            @(negedge CLK);
            START = 1'b0;
            if (c == 1) check($sformatf("tbl%0d_loadb_c1", r), CNT_LOADB, 0);
            if (TICK) begin
               nt++;
               if (first < 0) first = c;
               else if (second < 0) second = c;
            end
            if (DONE) begin
               donec = c;
               check($sformatf("tbl%0d_evt_at_done", r), EVT_COUNT, tbl[r].periods);
               check($sformatf("tbl%0d_busy_at_done", r), BUSY, 0);
               check($sformatf("tbl%0d_ticks", r), nt, tbl[r].periods);
            end
         end
         check($sformatf("tbl%0d_first_tick", r), first, tbl[r].first);
         check($sformatf("tbl%0d_done_cycle", r), donec, tbl[r].done_c);
         if (tbl[r].spacing != 0)
            check($sformatf("tbl%0d_spacing", r), second - first, tbl[r].spacing);
         @(negedge CLK);
         check($sformatf("tbl%0d_counter_left", r), cq, tbl[r].left);
      end

      // STOP in RUN after the first event
      start_run(1'b1, 4'd10, 8'd3);
      @(negedge CLK); START = 1'b0;
      repeat (11) @(negedge CLK);
      check("stop_pre_evt", EVT_COUNT, 1);
      STOP = 1'b1;
      @(negedge CLK); STOP = 1'b0;
      check("stop_obs", obs(), {4'd10, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1});
      repeat (20) @(negedge CLK);
      check("stop_stays_idle", {BUSY, TICK, DONE, EVT_COUNT}, {3'b000, 8'd1});

      // START and STOP together in IDLE
      @(negedge CLK); START = 1'b1; STOP = 1'b1; PRESET = 4'd5;
      @(negedge CLK); START = 1'b0; STOP = 1'b0;
      check("start_stop_idle", {BUSY, CNT_LOADB, CNT_A}, {1'b0, 1'b1, 4'd10});
      @(negedge CLK);
      check("start_stop_idle_next", BUSY, 0);

      // START while BUSY must not disturb timing or latched values
      start_run(1'b1, 4'd10, 8'd2);
      first = -1; donec = -1;
      for (int c = 1; c <= 30; c++) begin
         @(negedge CLK);
         START = (c == 4); STOP = 1'b0;
         if (c == 4) begin PRESET = 4'd0; DIR_UP = 1'b0; PERIODS = 8'd1; end
         if (c == 5) check("busy_start_latch", {CNT_A, CNT_U_DB}, {4'd10, 1'b1});
         if (TICK && first < 0) first = c;
         if (DONE) donec = c;
      end
      check("busy_start_first", first, 9);
      check("busy_start_done", donec, 17);

      // RST with an event pending (RCOB low in cycle 6 for down/3)
      start_run(1'b0, 4'd3, 8'd2);
      @(negedge CLK); START = 1'b0;
      repeat (5) @(negedge CLK);
      check("rst_pre_rcob", CNT_RCOB, 0);
      RST = 1'b1;
      @(negedge CLK); RST = 1'b0;
      check("rst_in_run", obs(), RESET_OBS);
      @(negedge CLK);
      check("rst_no_tick", {TICK, BUSY}, 0);

      // Free-run wrap of EVT_COUNT
      start_run(1'b1, 4'd14, 8'd0);
      nt = 0; evt255 = -1; evt256 = -1; saw_done = 0;
      for (int c = 1; c <= 1030; c++) begin
         @(negedge CLK); START = 1'b0;
         if (TICK) begin
            nt++;
            if (nt == 255) evt255 = EVT_COUNT;
            if (nt == 256) evt256 = EVT_COUNT;
         end
         if (DONE) saw_done = 1;
      end
      check("free_ticks", nt, 257);
      check("free_evt255", evt255, 255);
      check("free_evt_wrap", evt256, 0);
      check("free_no_done", saw_done, 0);
      STOP = 1'b1;
      @(negedge CLK); STOP = 1'b0;
      check("free_stopped", BUSY, 0);

      // Randomized runs against an arithmetic schedule: events at cycles 1 + k*(n+1)
      for (int it = 0; it < 40; it++) begin
         rdir = 1'($urandom_range(0, 1));
         rpre = 4'($urandom_range(0, 15));
         rper = 8'($urandom_range(0, 4));
         n    = rdir ? 17 - int'(rpre) : int'(rpre) + 2;
         dd   = 1 + int'(rper) * (n + 1);
         stopping = (rper == 0) || ($urandom_range(0, 2) == 0);
         s    = (rper == 0) ? int'($urandom_range(1, 80)) : int'($urandom_range(1, dd - 1));
         end_c = stopping ? s + 1 : dd;
         lim   = stopping ? s : dd;
         start_run(rdir, rpre, rper);
         for (int c = 1; c <= end_c + 1; c++) begin
            @(negedge CLK);
            lc      = (c < lim) ? c : lim;
            onb     = ((c - 1) % (n + 1)) == 0;
            busy_e  = c < end_c;
            tick_e  = (c >= 2) && onb && (c <= lim);
            done_e  = !stopping && (c == dd);
            evt_e   = 8'((lc - 1) / (n + 1));
            loadb_e = !(busy_e && (c == 1 || onb));
            enpb_e  = !(busy_e && loadb_e);
            check($sformatf("rnd%0d_c%0d", it, c), obs(),
                  {rpre, loadb_e, enpb_e, enpb_e, rdir, busy_e, tick_e, done_e, evt_e});
            STOP    = stopping && (c == s);
            START   = (c < end_c) ? 1'($urandom_range(0, 1)) : 1'b0;
            DIR_UP  = 1'($urandom_range(0, 1));
            PRESET  = 4'($urandom_range(0, 15));
            PERIODS = 8'($urandom_range(0, 255));
         end
         START = 1'b0; STOP = 1'b0;
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/sn74169_timer_ctrl.md
Name: sn74169_timer_ctrl

Overview:
Sequencer that turns one sn74169 up/down counter into a programmable interval timer.
- Loads a preset, enables counting, and watches the counter's registered ripple-carry (RCOB).
- Reloads after each terminal event and stops after a programmed number of events.
- Sits between a host command interface and the counter's A/LOADB/ENPB/ENTB/U_DB/RCOB pins. The counter itself is instantiated outside this block, next to it.

Parameters:
W, 4, counter width in bits (one sn74169 stage = 4)
EW, 8, width of PERIODS and EVT_COUNT

Ports:
CLK  in  1  single clock, rising edge
RST  in  1  synchronous reset, active-high
START  in  1  start request; sampled in IDLE only
STOP  in  1  abort request; highest priority after RST
DIR_UP  in  1  1 = count up, 0 = count down; latched on START
PRESET  in  W  counter load value; latched on START
PERIODS  in  EW  terminal events before DONE; 0 = free-run; latched on START
CNT_A  out  W  to counter A; drives latched PRESET
CNT_LOADB  out  1  to counter LOADB; low only in LOAD
CNT_ENPB  out  1  to counter ENPB; low only in RUN
CNT_ENTB  out  1  to counter ENTB; low only in RUN
CNT_U_DB  out  1  to counter U_DB; drives latched DIR_UP
CNT_RCOB  in  1  from counter RCOB; low = terminal value passed on the previous edge
BUSY  out  1  high in LOAD and RUN
TICK  out  1  one-cycle pulse per terminal event
DONE  out  1  one-cycle pulse on the final event
EVT_COUNT  out  EW  events since last START; wraps at 2^EW

Behaviour:
- All outputs are registered. CLK is the only clock. RST is synchronous, active-high, and overrides everything.
- Reset values:
  - state = IDLE
  - CNT_LOADB = CNT_ENPB = CNT_ENTB = 1
  - CNT_U_DB = 1, CNT_A = 0
  - BUSY = TICK = DONE = 0, EVT_COUNT = 0
- States: IDLE, LOAD, RUN.
- IDLE:
  - Enables and LOADB are high; the counter holds its value.
  - STOP=0 and START=1 at an edge: latch PRESET/DIR_UP/PERIODS, clear EVT_COUNT, go to LOAD.
  - START and STOP both high: STOP wins; remain in IDLE.
- LOAD (exactly 1 cycle):
  - CNT_LOADB=0; the counter loads PRESET on the edge ending this cycle.
  - Next state is RUN.
- RUN:
  - CNT_ENPB=CNT_ENTB=0.
  - First RUN cycle after every LOAD is blanking: CNT_RCOB is ignored, because the counter computes RCOB from its pre-load value.
  - From the 2nd RUN cycle on, CNT_RCOB=0 sampled at an edge is a terminal event.
- Terminal event: in the following cycle TICK=1 and EVT_COUNT = EVT_COUNT+1 (mod 2^EW).
  - If PERIODS != 0 and the new EVT_COUNT == PERIODS: DONE=1 in the same cycle, state IDLE, BUSY=0.
  - Otherwise: state LOAD (auto-reload).
- Counting continues during the cycle in which RCOB is low. The extra step is overwritten by the reload; after the final event the counter is left holding that value.
- RUN length n, counted from the first RUN cycle through the cycle in which RCOB is seen low:
  - up: n = 2^W + 1 − PRESET
  - down: n = PRESET + 2
  - TICK period = n + 1 cycles, including LOAD.
- Boundaries (W=4):
  - up PRESET=15 → n=2, the minimum.
  - down PRESET=0 → n=2.
  - up PRESET=0 → n=17.
  - down PRESET=15 → n=17.
- STOP in LOAD or RUN: next cycle IDLE, enables/LOADB high, BUSY=0. No TICK or DONE; EVT_COUNT keeps its value.
- START while BUSY is ignored. Changes to DIR_UP/PRESET/PERIODS while BUSY have no effect until the next START.
- RST mid-operation: next cycle reset values, regardless of state or pending event.
- Free-run (PERIODS=0): never DONE; EVT_COUNT wraps 2^EW−1 → 0 with TICK still pulsing.

Test Plan:
- W=4, up, PRESET=10, PERIODS=3, START pulse → CNT_LOADB=0 in cycle 1 after START; TICK at cycles 9, 17, 25; DONE with the 3rd TICK; BUSY low from that cycle; EVT_COUNT=3.
- Down, PRESET=3, PERIODS=1 → one LOAD then 5 RUN cycles; TICK+DONE on cycle 7 after START; counter left at 14.
- Up, PRESET=15, PERIODS=2 → stale RCOB in the blanking cycle ignored; TICK spacing 3 cycles; DONE on the 2nd TICK.
- PERIODS=0, up, PRESET=14 → TICK every 4 cycles indefinitely; EVT_COUNT wraps 255→0 after 256 TICKs; DONE never asserted.
- STOP mid-RUN at EVT_COUNT=1 → next cycle IDLE, ENPB/ENTB=1, BUSY=0, no TICK/DONE; EVT_COUNT stays 1. Also START+STOP together in IDLE → stays IDLE.
- RST in RUN, and START during BUSY → RST gives all reset values next cycle. A START pulse while BUSY does not alter timing or the latched PRESET.
